// File: rtl/rle_decode.sv
// rtl/rle_decode.sv - run-length decoder: {byte,count} entry words in DPSRAM -> packed plaintext words.
module rle_decode (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic [31:0] rle_addr,
  input  logic [31:0] rle_size,
  input  logic [31:0] out_addr,
  output logic [31:0] out_size,
  output logic        done,
  output logic        port_A_clk,
  output logic [15:0] port_A_addr,
  output logic [31:0] port_A_data_in,
  input  logic [31:0] port_A_data_out,
  output logic        port_A_we
);

  typedef enum logic [2:0] {IDLE, READ, LATCH, EXPAND, WRITE, FLUSH} state_t;

  state_t      state, state_n;
  logic [15:0] rd_ptr, wr_ptr;
  logic [29:0] words_left;
  logic [31:0] word_reg, asm_reg;
  logic [7:0]  run_left;
  logic [2:0]  fill;
  logic        half, word_done;
  logic        emit, advance;
  logic [7:0]  cur_byte;

  assign port_A_clk     = clk;
  assign port_A_addr    = port_A_we ? wr_ptr : rd_ptr;
  assign port_A_data_in = asm_reg;
  assign cur_byte       = half ? word_reg[31:24] : word_reg[15:8];

  // An entry retires on the cycle its last byte is emitted, so runs chain without bubbles;
  // a count-0 entry retires in a cycle of its own.
  always_comb begin
    state_n   = state;
    port_A_we = 1'b0;
    emit      = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE:  if (start) state_n = (rle_size[31:2] == 30'd0) ? FLUSH : READ;
      READ:  state_n = LATCH;
      LATCH: state_n = EXPAND;
      EXPAND: begin
        emit    = (run_left != 8'd0);
        advance = (run_left <= 8'd1);
        if (emit && fill == 3'd3)
          state_n = WRITE;
        else if (advance && half)
          state_n = (words_left != 30'd0) ? READ : FLUSH;
      end
      WRITE: begin
        port_A_we = 1'b1;
        if (word_done) state_n = (words_left != 30'd0) ? READ : FLUSH;
        else           state_n = EXPAND;
      end
      FLUSH: begin
        port_A_we = (fill != 3'd0);
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      rd_ptr     <= 16'd0;
      wr_ptr     <= 16'd0;
      words_left <= 30'd0;
      word_reg   <= 32'd0;
      asm_reg    <= 32'd0;
      run_left   <= 8'd0;
      fill       <= 3'd0;
      half       <= 1'b0;
      word_done  <= 1'b0;
      out_size   <= 32'd0;
      done       <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          rd_ptr     <= rle_addr[15:0];
          wr_ptr     <= out_addr[15:0];
          words_left <= rle_size[31:2];
          out_size   <= 32'd0;
          fill       <= 3'd0;
          asm_reg    <= 32'd0;
          done       <= 1'b0;
        end
        READ: begin
          rd_ptr     <= rd_ptr + 16'd4;
          words_left <= words_left - 30'd1;
        end
        LATCH: begin
          word_reg  <= port_A_data_out;
          run_left  <= port_A_data_out[7:0];
          half      <= 1'b0;
          word_done <= 1'b0;
        end
        EXPAND: begin
          if (emit) begin
            asm_reg[{fill[1:0], 3'b000} +: 8] <= cur_byte;
            fill     <= fill + 3'd1;
            out_size <= out_size + 32'd1;
            run_left <= run_left - 8'd1;
          end
          if (advance) begin
            if (!half) begin
              half     <= 1'b1;
              run_left <= word_reg[23:16];
            end else begin
              word_done <= 1'b1;
            end
          end
        end
        WRITE: begin
          wr_ptr  <= wr_ptr + 16'd4;
          fill    <= 3'd0;
          asm_reg <= 32'd0;
        end
        FLUSH: begin
          if (fill != 3'd0) wr_ptr <= wr_ptr + 16'd4;
          fill    <= 3'd0;
          asm_reg <= 32'd0;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
